// File: rtl/rx_byte_packer.sv
// rx_byte_packer: detects link-up from a run of BC idle symbols, strips idles and packs payload bytes into 32-bit words.
// Latency: a word appears on data_out, with a one-cycle valid_out pulse, the cycle after the edge that samples its 4th payload byte.
// Backpressure: none; the consumer must accept every valid_out pulse.
//
// Ports:
//   clk4f     - byte clock, rising edge
//   reset     - asynchronous, active-high
//   data_in   - byte from the serial-to-parallel stage, qualified by valid_in
//   data_out  - packed word, first received byte in [31:24], last in [7:0]
//   valid_out - one-cycle pulse, data_out holds a new word
//   active    - high while the link is up (ACTIVE state)
//
// Optional feature, macro RX_PACKER_FLUSH_EN: a BC idle arriving mid-word flushes the
// partial word with unfilled lanes set to 8'h00. Without it, partial words wait across idles.
module rx_byte_packer #(
    parameter logic [7:0] BC_SYMBOL  = 8'hBC,
    parameter int         BC_COUNT   = 4,
    parameter int         LOSS_LIMIT = 8
) (
    input  logic        clk4f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active
);

    localparam int BCW = $clog2(BC_COUNT + 1);
    localparam int LW  = $clog2(LOSS_LIMIT + 1);

    localparam logic [BCW-1:0] BC_LAST   = BCW'(BC_COUNT - 1);
    localparam logic [LW-1:0]  LOSS_LAST = LW'(LOSS_LIMIT - 1);
    localparam logic [LW-1:0]  LOSS_MAX  = LW'(LOSS_LIMIT);

    typedef enum logic {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [BCW-1:0]  bc_cnt, bc_nxt;
    logic [1:0]      byte_idx, idx_nxt;
    logic [LW-1:0]   loss_cnt, loss_nxt;
    logic [31:0]     hold, hold_nxt;
    logic [31:0]     dout_nxt;
    logic            vout_nxt;
    logic [31:0]     packed_w;
    logic            is_bc;

    assign is_bc = (data_in == BC_SYMBOL);

    // Holding register with the incoming byte dropped into its lane.
    // hold is cleared whenever a word leaves, so lanes past byte_idx are always zero.
    always_comb begin
        packed_w = hold;
        case (byte_idx)
            2'd0:    packed_w[31:24] = data_in;
            2'd1:    packed_w[23:16] = data_in;
            2'd2:    packed_w[15:8]  = data_in;
            default: packed_w[7:0]   = data_in;
        endcase
    end

    always_comb begin
        state_nxt = state;
        bc_nxt    = bc_cnt;
        idx_nxt   = byte_idx;
        loss_nxt  = loss_cnt;
        hold_nxt  = hold;
        dout_nxt  = data_out;
        vout_nxt  = 1'b0;

        case (state)
            SEARCH: begin
                if (valid_in) begin
                    if (is_bc) begin
                        if (bc_cnt == BC_LAST) begin
                            state_nxt = ACTIVE;
                            bc_nxt    = '0;
                            idx_nxt   = 2'd0;
                            loss_nxt  = '0;
                            hold_nxt  = 32'h0;
                        end else begin
                            bc_nxt = bc_cnt + 1'b1;
                        end
                    end else begin
                        bc_nxt = '0;
                    end
                end
            end

            ACTIVE: begin
                if (valid_in) begin
                    loss_nxt = '0;
                    if (is_bc) begin
`ifdef RX_PACKER_FLUSH_EN
                        if (byte_idx != 2'd0) begin
                            dout_nxt = hold;
                            vout_nxt = 1'b1;
                            idx_nxt  = 2'd0;
                            hold_nxt = 32'h0;
                        end
`endif
                    end else begin
                        idx_nxt = byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            dout_nxt = packed_w;
                            vout_nxt = 1'b1;
                            hold_nxt = 32'h0;
                        end else begin
                            hold_nxt = packed_w;
                        end
                    end
                end else begin
                    if (loss_cnt == LOSS_LAST) begin
                        // Link lost: partial word is discarded, counters restart.
                        state_nxt = SEARCH;
                        bc_nxt    = '0;
                        idx_nxt   = 2'd0;
                        loss_nxt  = '0;
                        hold_nxt  = 32'h0;
                    end else if (loss_cnt != LOSS_MAX) begin
                        loss_nxt = loss_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk4f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            bc_cnt    <= '0;
            byte_idx  <= 2'd0;
            loss_cnt  <= '0;
            hold      <= 32'h0;
            data_out  <= 32'h0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bc_cnt    <= bc_nxt;
            byte_idx  <= idx_nxt;
            loss_cnt  <= loss_nxt;
            hold      <= hold_nxt;
            data_out  <= dout_nxt;
            valid_out <= vout_nxt;
            active    <= (state_nxt == ACTIVE);
        end
    end

endmodule

// File: doc/rx_byte_packer.md
Name: rx_byte_packer

Overview:
- Downstream stage of the serial-to-parallel converter, in the clk4f domain.
- Consumes its 8-bit out/valid byte stream, detects link-up from consecutive BC (K28.5, 8'hBC) symbols and strips idle BC symbols.
- Packs payload bytes into 32-bit words for the upper receive logic.
- Drops link and discards any partial word on a sustained loss of valid.

Parameters:
- BC_SYMBOL, 8'hBC, idle/alignment symbol value.
- BC_COUNT, 4, consecutive valid BC bytes required to enter ACTIVE.
- LOSS_LIMIT, 8, consecutive valid_in-low cycles in ACTIVE that force return to SEARCH.

Ports:
- clk4f  input  1  byte clock, rising-edge.
- reset  input  1  reset; asynchronous, active-high.
- data_in  input  8  byte from the serial-to-parallel stage.
- valid_in  input  1  data_in qualifier.
- data_out  output  32  packed word; first received byte in [31:24], last in [7:0].
- valid_out  output  1  one-cycle pulse, data_out holds a new word.
- active  output  1  high while in ACTIVE state.

Behaviour:
- One clock, clk4f. reset is asynchronous and active-high.
- All outputs and state are registered.
- Reset (asynchronous, any time, including mid-word) clears the following; the first edge after deassertion is a normal SEARCH cycle:
  - data_out=32'h0, valid_out=0, active=0.
  - state=SEARCH, bc_cnt=0, byte_idx=0, loss_cnt=0, holding register=0.
- SEARCH:
  - valid_in=1 and data_in==BC_SYMBOL: bc_cnt++.
  - Any valid non-BC byte resets bc_cnt to 0.
  - valid_in=0 holds bc_cnt.
  - When the BC_COUNT-th consecutive BC is sampled: next state ACTIVE, active=1 from the following cycle, byte_idx=0.
  - No bytes are packed in SEARCH.
- ACTIVE, valid_in=1, data_in==BC_SYMBOL: idle byte.
  - Dropped; byte_idx and holding register unchanged.
  - loss_cnt cleared.
- ACTIVE, valid_in=1, non-BC byte:
  - Written to lane byte_idx (0 maps to [31:24]); byte_idx++; loss_cnt cleared.
  - On the byte making byte_idx wrap 3->0: full word copied to data_out, valid_out=1 for exactly one cycle.
  - Latency: word visible on the cycle after the edge that sampled its 4th byte.
- data_out holds its last value between pulses. Back-to-back words produce valid_out high on consecutive 4-byte boundaries only; there is never more than one pulse per 4 payload bytes.
- ACTIVE, valid_in=0:
  - loss_cnt++ (saturating).
  - On reaching LOSS_LIMIT: state=SEARCH, active=0, bc_cnt=0, byte_idx=0, partial word discarded, no valid_out.
  - loss_cnt cleared on exit.
- Simultaneous events:
  - The word-completing byte sampled on the same edge as a loss-limit hit cannot occur, since loss needs valid_in=0.
  - A 4th byte always produces its pulse before any later exit.
- No backpressure: the consumer must accept every valid_out pulse.

Optional Feature:
- Macro: RX_PACKER_FLUSH_EN.
- Defined: in ACTIVE, a BC idle byte arriving while byte_idx!=0 flushes the partial word.
  - Unfilled lanes are set to 8'h00.
  - data_out updated and valid_out pulses the next cycle; byte_idx=0.
  - A BC with byte_idx==0 is dropped as normal.
- Not defined: partial words are retained across idles until completed or discarded by loss/reset.

Test Plan:
1. SEARCH entry: reset, then 4 valid 8'hBC -> active=0 through the 4th edge, active=1 the next cycle; data_out=0, valid_out=0.
2. Partial alignment: 3x BC, 8'h11, 4x BC -> active rises only after the final 4 BCs; 8'h11 is not packed.
3. Packing with idles: ACTIVE, then bytes 8'hA1,8'hBC,8'hB2,8'hC3,8'hBC,8'hD4 -> single valid_out pulse, data_out=32'hA1B2C3D4 one cycle after D4; no pulse on the idles.
4. Back-to-back: 8 consecutive payload bytes 01..08 -> pulses with 32'h01020304 then 32'h05060708, exactly 4 cycles apart.
5. Loss of link: ACTIVE, bytes 8'hAA,8'hBB, then valid_in=0 for 8 cycles -> active=0 after the 8th; no pulse. Re-align with 4 BC, then 4 payload bytes -> word contains only the new bytes.
6. Async reset mid-word, and flush:
   - Assert reset between clk4f edges after 2 payload bytes -> outputs clear immediately, without waiting for an edge.
   - With RX_PACKER_FLUSH_EN, ACTIVE, bytes 8'h5A,8'h6B then BC -> data_out=32'h5A6B0000 with a valid_out pulse.
   - Without the macro, no pulse for that sequence.
